// File: rtl/cuenta_regresiva_pkg.sv
// Shared definitions for the BCD countdown timer: FSM encoding, digit limits
// and the preset clamp used by every digit.
package cuenta_regresiva_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  localparam logic [3:0] DIGIT_MAX   = 4'd9;
  localparam logic [3:0] SEG_DEC_MAX = 4'd5;

  // Out-of-range presets saturate to the digit's maximum.
  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max_v);
    return (d > max_v) ? max_v : d;
  endfunction

endpackage

// File: rtl/cuenta_regresiva_bcd_digit_dec.sv
// One BCD down-counting digit. Wraps 0 -> MAX on a borrow and passes the
// borrow on to the next more-significant digit.
module bcd_digit_dec
  import cuenta_regresiva_pkg::*;
#(
  parameter logic [3:0] MAX = DIGIT_MAX
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       borrow_in,
  input  logic       load,
  input  logic [3:0] preset,
  output logic [3:0] digit,
  output logic       borrow_out
);

  logic [3:0] r_digit;

  // A borrow leaves this digit only when it has nothing left to give.
  assign borrow_out = borrow_in && (r_digit == 4'd0);
  assign digit      = r_digit;

  // Load takes precedence over counting; the borrow decrements or wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_digit <= 4'd0;
    end else if (load) begin
      r_digit <= clamp_digit(preset, MAX);
    end else if (borrow_in) begin
      r_digit <= (r_digit == 4'd0) ? MAX : (r_digit - 4'd1);
    end
  end

endmodule

// File: rtl/cuenta_regresiva.sv
// BCD countdown timer: five chained down-counting digits (seg_dec:seg:cent:dec:count)
// controlled by an IDLE/RUN/PAUSE/EXPIRED FSM with a one-cycle done pulse.
module cuenta_regresiva
  import cuenta_regresiva_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       load,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] pre_count,
  input  logic [3:0] pre_dec,
  input  logic [3:0] pre_cent,
  input  logic [3:0] pre_seg,
  input  logic [3:0] pre_seg_dec,
  output logic [3:0] count,
  output logic [3:0] dec,
  output logic [3:0] cent,
  output logic [3:0] seg,
  output logic [3:0] seg_dec,
  output logic       running,
  output logic       expired,
  output logic       done
);

  state_t r_state;
  logic   r_running;
  logic   r_expired;
  logic   r_done;

  logic   w_dec_en;
  logic   w_zero;
  logic   w_one;
  logic   w_b_dec;
  logic   w_b_cent;
  logic   w_b_seg;
  logic   w_b_seg_dec;
  logic   w_b_top;

  // Decrement only in RUN with no higher-priority load or stop this cycle.
  assign w_dec_en = (r_state == ST_RUN) && enable && !load && !stop;

  // Zero detect gates start; "one" detect predicts the zero crossing so done
  // and EXPIRED land on the same edge as the all-zero digits.
  assign w_zero = ~|{seg_dec, seg, cent, dec, count};
  assign w_one  = (count == 4'd1) && ~|{seg_dec, seg, cent, dec};

  bcd_digit_dec #(.MAX(DIGIT_MAX)) u_count (
    .clk(clk), .rst(rst), .borrow_in(w_dec_en), .load(load),
    .preset(pre_count), .digit(count), .borrow_out(w_b_dec)
  );

  bcd_digit_dec #(.MAX(DIGIT_MAX)) u_dec (
    .clk(clk), .rst(rst), .borrow_in(w_b_dec), .load(load),
    .preset(pre_dec), .digit(dec), .borrow_out(w_b_cent)
  );

  bcd_digit_dec #(.MAX(DIGIT_MAX)) u_cent (
    .clk(clk), .rst(rst), .borrow_in(w_b_cent), .load(load),
    .preset(pre_cent), .digit(cent), .borrow_out(w_b_seg)
  );

  bcd_digit_dec #(.MAX(DIGIT_MAX)) u_seg (
    .clk(clk), .rst(rst), .borrow_in(w_b_seg), .load(load),
    .preset(pre_seg), .digit(seg), .borrow_out(w_b_seg_dec)
  );

  // The final borrow out is never taken: RUN is never entered at zero.
  bcd_digit_dec #(.MAX(SEG_DEC_MAX)) u_seg_dec (
    .clk(clk), .rst(rst), .borrow_in(w_b_seg_dec), .load(load),
    .preset(pre_seg_dec), .digit(seg_dec), .borrow_out(w_b_top)
  );

  // Control FSM with registered status flags; priority load > stop > start > enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_running <= 1'b0;
      r_expired <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (load) begin
        r_state   <= ST_IDLE;
        r_running <= 1'b0;
        r_expired <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE, ST_PAUSE: begin
            if (start && !w_zero) begin
              r_state   <= ST_RUN;
              r_running <= 1'b1;
            end
          end
          ST_RUN: begin
            if (stop) begin
              r_state   <= ST_PAUSE;
              r_running <= 1'b0;
            end else if (enable && w_one) begin
              r_state   <= ST_EXPIRED;
              r_running <= 1'b0;
              r_expired <= 1'b1;
              r_done    <= 1'b1;
            end
          end
          ST_EXPIRED: begin
            r_state <= ST_EXPIRED;
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign running = r_running;
  assign expired = r_expired;
  assign done    = r_done;

  logic w_unused;
  assign w_unused = w_b_top;

endmodule

// File: tb/tb_cuenta_regresiva.sv
// Directed bench for the BCD countdown timer.
module tb_cuenta_regresiva;

  logic       clk = 1'b0;
  logic       rst, enable, load, start, stop;
  logic [3:0] pre_count, pre_dec, pre_cent, pre_seg, pre_seg_dec;
  logic [3:0] count, dec, cent, seg, seg_dec;
  logic       running, expired, done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cuenta_regresiva dut (
    .clk(clk), .rst(rst), .enable(enable), .load(load), .start(start), .stop(stop),
    .pre_count(pre_count), .pre_dec(pre_dec), .pre_cent(pre_cent),
    .pre_seg(pre_seg), .pre_seg_dec(pre_seg_dec),
    .count(count), .dec(dec), .cent(cent), .seg(seg), .seg_dec(seg_dec),
    .running(running), .expired(expired), .done(done)
  );

  function automatic logic [19:0] value();
    return {seg_dec, seg, cent, dec, count};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_preset(input logic [19:0] p);
    {pre_seg_dec, pre_seg, pre_cent, pre_dec, pre_count} = p;
  endtask

  task automatic clear_ctl();
    rst = 1'b0; enable = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_flags(input string tag, input logic r, input logic x, input logic d);
    chk({tag, "_running"}, {19'd0, running}, {19'd0, r});
    chk({tag, "_expired"}, {19'd0, expired}, {19'd0, x});
    chk({tag, "_done"},    {19'd0, done},    {19'd0, d});
  endtask

  task automatic do_load(input logic [19:0] p);
    clear_ctl(); set_preset(p); load = 1'b1; tick(); clear_ctl();
  endtask

  task automatic pulse_start();
    clear_ctl(); start = 1'b1; tick(); clear_ctl();
  endtask

  initial begin
    clear_ctl();
    set_preset(20'h0);

    // Reset with random activity on the other inputs
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      {enable, load, start, stop} = 4'($urandom_range(0, 15));
      set_preset(20'($urandom));
      tick();
    end
    chk("reset_value", value(), 20'h00000);
    chk_flags("reset", 1'b0, 1'b0, 1'b0);
    clear_ctl();

    // Borrow through the whole chain
    do_load(20'h10000);
    chk("borrow_load", value(), 20'h10000);
    chk("borrow_idle_running", {19'd0, running}, 20'd0);
    pulse_start();
    chk("borrow_start_running", {19'd0, running}, 20'd1);
    chk("borrow_start_hold", value(), 20'h10000);
    enable = 1'b1; tick(); enable = 1'b0;
    chk("borrow_value", value(), 20'h09999);
    chk_flags("borrow", 1'b1, 1'b0, 1'b0);

    // Zero crossing
    do_load(20'h00003);
    pulse_start();
    enable = 1'b1; tick(); tick();
    chk("zc_two", value(), 20'h00001);
    chk_flags("zc_two", 1'b1, 1'b0, 1'b0);
    tick(); enable = 1'b0;
    chk("zc_zero", value(), 20'h00000);
    chk_flags("zc_zero", 1'b0, 1'b1, 1'b1);
    tick();
    chk_flags("zc_after", 1'b0, 1'b1, 1'b0);
    enable = 1'b1; tick(); enable = 1'b0;
    chk("zc_extra_enable", value(), 20'h00000);
    chk_flags("zc_extra", 1'b0, 1'b1, 1'b0);

    // Pause and resume
    do_load(20'h00010);
    pulse_start();
    enable = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("pause_4", value(), 20'h00006);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("pause_stop_enable", value(), 20'h00006);
    chk("pause_running", {19'd0, running}, 20'd0);
    for (int i = 0; i < 3; i++) tick();
    enable = 1'b0;
    chk("pause_hold", value(), 20'h00006);
    pulse_start();
    chk("pause_resume_running", {19'd0, running}, 20'd1);
    enable = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("pause_one", value(), 20'h00001);
    chk_flags("pause_one", 1'b1, 1'b0, 1'b0);
    tick(); enable = 1'b0;
    chk("pause_zero", value(), 20'h00000);
    chk_flags("pause_zero", 1'b0, 1'b1, 1'b1);
    tick();
    chk("pause_done_drop", {19'd0, done}, 20'd0);

    // Clamp of out-of-range presets, maximum value, zero start
    do_load(20'h7C00F);
    chk("clamp", value(), 20'h59009);
    do_load(20'h59999);
    chk("max_load", value(), 20'h59999);
    do_load(20'h00000);
    pulse_start();
    chk("zero_start_value", value(), 20'h00000);
    chk_flags("zero_start", 1'b0, 1'b0, 1'b0);
    enable = 1'b1; tick(); enable = 1'b0;
    chk_flags("zero_start_en", 1'b0, 1'b0, 1'b0);

    // Priority: load beats stop and enable in RUN
    do_load(20'h00005);
    pulse_start();
    enable = 1'b1; tick(); enable = 1'b0;
    chk("prio_run", value(), 20'h00004);
    set_preset(20'h00300);
    load = 1'b1; stop = 1'b1; enable = 1'b1; tick(); clear_ctl();
    chk("prio_load", value(), 20'h00300);
    chk_flags("prio_load", 1'b0, 1'b0, 1'b0);
    enable = 1'b1; tick(); enable = 1'b0;
    chk("prio_idle_enable", value(), 20'h00300);

    // start and enable together in RUN: start ignored, decrement happens
    pulse_start();
    start = 1'b1; enable = 1'b1; tick(); clear_ctl();
    chk("run_start_enable", value(), 20'h00299);

    // Reset beats load, also mid-count
    set_preset(20'h12345);
    rst = 1'b1; load = 1'b1; enable = 1'b1; tick(); clear_ctl();
    chk("rst_over_load", value(), 20'h00000);
    chk_flags("rst_over_load", 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cuenta_regresiva.md
# cuenta_regresiva

BCD countdown timer, the down-counting counterpart of the stopwatch up-counter. It loads a preset time as five BCD digits, decrements once per `enable` tick while running, and stops at zero with a one-cycle `done` pulse. Digit layout and ranges match the stopwatch, so the same display path drives either block.
- Digit chain, least to most significant: `count`, `dec`, `cent` (0–9 each), `seg` (0–9), `seg_dec` (0–5).

## Interface
Parameters: none.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: tick strobe, one decrement per high cycle while in RUN.
- `load` in 1: copy preset digits into the counter.
- `start` in 1: begin or resume the countdown.
- `stop` in 1: pause the countdown.
- `pre_count`, `pre_dec`, `pre_cent`, `pre_seg`, `pre_seg_dec` in 4 each: preset digits.
- `count`, `dec`, `cent`, `seg`, `seg_dec` out 4 each: current digits, registered.
- `running` out 1: high in RUN.
- `expired` out 1: high in EXPIRED.
- `done` out 1: one-cycle pulse when the value reaches zero.

## Operation
- Reset (`rst`=1 at a clock edge): all digits 0, state IDLE, `running`=0, `expired`=0, `done`=0.
- States:
  - IDLE: value held.
  - RUN: decrementing.
  - PAUSE: value held.
  - EXPIRED: value 0 held.
- Priority per cycle: `rst` > `load` > `stop` > `start` > `enable`.
- `load`, any state:
  - Digits take the preset values, clamped: a preset digit >9 loads 9; `pre_seg_dec` >5 loads 5.
  - Next state IDLE, `done`=0.
- `start` in IDLE or PAUSE:
  - Value nonzero: go to RUN.
  - Value all-zero: ignored, stay in current state.
  - In RUN or EXPIRED: ignored.
- `stop` in RUN: go to PAUSE, no decrement that cycle. In other states: ignored.
- `enable` in RUN (no higher-priority input): decrement with borrow.
  - `count`>0: `count`−1.
  - Otherwise `count`←9 and borrow into `dec`; same rule up through `seg`.
  - `seg_dec` absorbs the final borrow as `seg_dec`−1. Underflow cannot occur, because RUN is never entered at zero.
- Zero crossing: if the decrement produces all-zero digits, next state is EXPIRED and `done`=1 for exactly that one cycle.
- EXPIRED holds zeros until `load` or `rst`.
- `enable` outside RUN has no effect.
- All digits update on the same edge; there is no ripple across cycles.

## Timing
- All outputs are registered. Every input is sampled on a rising edge and takes effect on that edge.
- `start` sampled high at edge N: `running`=1 after N. The first decrement occurs at the first edge >N with `enable`=1.
- Decrement latency: 1 cycle from the `enable` edge to new digits.
- `done` asserts at the same edge the digits become 0 and `expired` rises; `done` deasserts one cycle later.
- `stop` and `enable` in the same cycle: PAUSE, value unchanged.
- `load` during RUN: new value and IDLE at the next edge; no decrement that cycle.
- `rst` mid-count: zeros and IDLE at the next edge, regardless of the other inputs.
- Maximum value 5-9-9-9-9 = 59999 ticks.

## Structure
- Shared package:
  - State encoding (IDLE, RUN, PAUSE, EXPIRED).
  - Digit limit constants: `DIGIT_MAX`=9, `SEG_DEC_MAX`=5.
- Sub-module `bcd_digit_dec`:
  - One digit with parameter MAX; inputs `borrow_in`, `load`, preset; outputs digit and `borrow_out` (asserted when the digit is 0 and `borrow_in`=1).
  - Five instances chained: `count`'s `borrow_in` = decrement-enable, `seg_dec` uses MAX=5.
- Top level holds the FSM, zero detect (NOR of all digits) and the `done` register.

## Test plan
- Reset: hold `rst` 2 cycles with random inputs → all digits 0, IDLE, all flags 0.
- Borrow chain: load 1-0-0-0-0, start, one `enable` → `seg_dec`=0, `seg`=9, `cent`=9, `dec`=9, `count`=9; `running`=1.
- Zero crossing: load 0-0-0-0-3, start, 3 `enable` pulses → digits 0 after the third; `done` high exactly one cycle; `expired`=1; a further `enable` changes nothing.
- Pause: load 0-0-0-1-0, start, 4 `enable`, `stop` asserted together with the 5th `enable`, 3 more `enable`, then `start`, 6 `enable` → value 0-0-0-0-6 held during PAUSE; final value 0 with `done` pulse.
- Clamp and zero start: load presets 7-C-0-0-F → value 5-9-0-0-9. Load all zeros, then `start` → stays IDLE, `running`=0, no `done`.
- Priority: `load`, `stop` and `enable` together in RUN → preset loaded, IDLE, no decrement. `rst` asserted together with `load` → zeros.
